// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: registered sync/blank/prefetch coordinates
// derived from the next counter state, plus combinational colour gating.
module vga_timing_gen #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACT    = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACT    = 480,
    parameter int V_FRONT  = 10,
    parameter int PIX_LEAD = 2
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [3:0] iCursor_RGB_EN,
    input  logic [9:0] iRed,
    input  logic [9:0] iGreen,
    input  logic [9:0] iBlue,
    output logic [9:0] oCoord_X,
    output logic [9:0] oCoord_Y,
    output logic [9:0] oVGA_R,
    output logic [9:0] oVGA_G,
    output logic [9:0] oVGA_B,
    output logic       oVGA_H_SYNC,
    output logic       oVGA_V_SYNC,
    output logic       oVGA_SYNC,
    output logic       oVGA_BLANK
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int H_END   = H_START + H_ACT;
    localparam int V_START = V_SYNC + V_BACK;
    localparam int V_END   = V_START + V_ACT;

    logic [9:0]  h_cnt, v_cnt;
    logic [9:0]  h_nxt, v_nxt;
    logic [10:0] hp_nxt;
    logic        h_act_nxt, v_act_nxt, hp_act_nxt;
    logic        unused_en3;

    assign unused_en3 = iCursor_RGB_EN[3];

    // Outputs are computed from the next counter value so they land in the
    // same cycle as the counter they describe.
    always_comb begin
        h_nxt = h_cnt + 10'd1;
        v_nxt = v_cnt;
        if (h_cnt == 10'(H_TOTAL - 1)) begin
            h_nxt = '0;
            if (v_cnt == 10'(V_TOTAL - 1))
                v_nxt = '0;
            else
                v_nxt = v_cnt + 10'd1;
        end
        hp_nxt     = {1'b0, h_nxt} + 11'(PIX_LEAD);
        h_act_nxt  = (h_nxt >= 10'(H_START)) && (h_nxt < 10'(H_END));
        v_act_nxt  = (v_nxt >= 10'(V_START)) && (v_nxt < 10'(V_END));
        hp_act_nxt = (hp_nxt >= 11'(H_START)) && (hp_nxt < 11'(H_END));
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            h_cnt       <= 10'(H_TOTAL - 1);
            v_cnt       <= 10'(V_TOTAL - 1);
            oVGA_H_SYNC <= 1'b1;
            oVGA_V_SYNC <= 1'b1;
            oVGA_BLANK  <= 1'b0;
            oCoord_X    <= '0;
            oCoord_Y    <= '0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            oVGA_H_SYNC <= !(h_nxt < 10'(H_SYNC));
            oVGA_V_SYNC <= !(v_nxt < 10'(V_SYNC));
            oVGA_BLANK  <= h_act_nxt && v_act_nxt;
            if (hp_act_nxt && v_act_nxt) begin
                oCoord_X <= 10'(hp_nxt - 11'(H_START));
                oCoord_Y <= v_nxt - 10'(V_START);
            end else begin
                oCoord_X <= '0;
                oCoord_Y <= '0;
            end
        end
    end

    assign oVGA_SYNC = 1'b1;
    assign oVGA_R    = (oVGA_BLANK && iCursor_RGB_EN[2]) ? iRed   : '0;
    assign oVGA_G    = (oVGA_BLANK && iCursor_RGB_EN[1]) ? iGreen : '0;
    assign oVGA_B    = (oVGA_BLANK && iCursor_RGB_EN[0]) ? iBlue  : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 640x480 instance plus a tiny-geometry
// instance (17x9 frame) used for frame-period and last-line checks.
module tb_vga_timing_gen;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic [3:0] en = 4'b0111;
    logic [9:0] iRed = 10'h3FF, iGreen = 10'h2AA, iBlue = 10'h155;

    logic [9:0] cx, cy, r, g, b;
    logic       hs, vs, sy, bl;
    logic [9:0] s_cx, s_cy, s_r, s_g, s_b;
    logic       s_hs, s_vs, s_sy, s_bl;

    int passed = 0;
    int total  = 0;
    int ecount = 0;

    always #5 iCLK = ~iCLK;

    vga_timing_gen dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCursor_RGB_EN(en),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oCoord_X(cx), .oCoord_Y(cy), .oVGA_R(r), .oVGA_G(g), .oVGA_B(b),
        .oVGA_H_SYNC(hs), .oVGA_V_SYNC(vs), .oVGA_SYNC(sy), .oVGA_BLANK(bl)
    );

    vga_timing_gen #(
        .H_SYNC(4), .H_BACK(3), .H_ACT(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_ACT(4), .V_FRONT(1), .PIX_LEAD(2)
    ) dut_s (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCursor_RGB_EN(en),
        .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
        .oCoord_X(s_cx), .oCoord_Y(s_cy), .oVGA_R(s_r), .oVGA_G(s_g), .oVGA_B(s_b),
        .oVGA_H_SYNC(s_hs), .oVGA_V_SYNC(s_vs), .oVGA_SYNC(s_sy), .oVGA_BLANK(s_bl)
    );

    // ecount = number of edges since release; edge n holds h=(n-1) mod 800
    task automatic tick();
        @(posedge iCLK);
        #1;
        if (iRST_N) ecount++;
        else ecount = 0;
    endtask

    task automatic advance_to(input int h, input int v);
        int target;
        target = v * 800 + h + 1;
        total++;
        if (target < ecount) $display("FAIL advance_to got edge %0d exp <= %0d", ecount, target);
        else passed++;
        while (ecount < target) tick();
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        repeat (5) tick();
        total++; if (hs !== 1'b1) $display("FAIL rst_hs got %b exp 1", hs); else passed++;
        total++; if (vs !== 1'b1) $display("FAIL rst_vs got %b exp 1", vs); else passed++;
        total++; if (bl !== 1'b0) $display("FAIL rst_blank got %b exp 0", bl); else passed++;
        total++; if (sy !== 1'b1) $display("FAIL rst_sync got %b exp 1", sy); else passed++;
        total++; if ({r, g, b} !== 30'h0) $display("FAIL rst_rgb got %h exp 0", {r, g, b}); else passed++;
        total++; if ({cx, cy} !== 20'h0) $display("FAIL rst_coord got %h exp 0", {cx, cy}); else passed++;
        iRST_N = 1'b1;
        tick();
        total++; if (hs !== 1'b0) $display("FAIL rel_hs_edge1 got %b exp 0", hs); else passed++;
        total++; if (vs !== 1'b0) $display("FAIL rel_vs_edge1 got %b exp 0", vs); else passed++;
        advance_to(95, 0);
        total++; if (hs !== 1'b0) $display("FAIL hs_edge96 got %b exp 0", hs); else passed++;
        advance_to(96, 0);
        total++; if (hs !== 1'b1) $display("FAIL hs_edge97 got %b exp 1", hs); else passed++;
    endtask

    task automatic test_line_frame();
        int last_fall = 1, falls = 0;
        int s_last_vfall = 1, s_vfalls = 0;
        logic prev_hs, s_prev_vs;
        prev_hs = hs;
        s_prev_vs = s_vs;
        while (ecount < 2401) begin
            tick();
            if (prev_hs && !hs) begin
                total++; if (ecount - last_fall != 800) $display("FAIL hs_period got %0d exp 800", ecount - last_fall); else passed++;
                last_fall = ecount;
                falls++;
            end
            if (s_prev_vs && !s_vs) begin
                total++; if (ecount - s_last_vfall != 153) $display("FAIL s_frame_period got %0d exp 153", ecount - s_last_vfall); else passed++;
                s_last_vfall = ecount;
                s_vfalls++;
            end
            if (!s_prev_vs && s_vs) begin
                total++; if (ecount - s_last_vfall != 34) $display("FAIL s_vs_width got %0d exp 34", ecount - s_last_vfall); else passed++;
            end
            if (ecount == 1600) begin
                total++; if (vs !== 1'b0) $display("FAIL vs_edge1600 got %b exp 0", vs); else passed++;
            end
            if (ecount == 1601) begin
                total++; if (vs !== 1'b1) $display("FAIL vs_edge1601 got %b exp 1", vs); else passed++;
            end
            if (ecount == 132 || ecount == 285) begin
                total++; if ({s_cx, s_cy} !== {10'd7, 10'd3}) $display("FAIL s_last_coord got %0d,%0d exp 7,3", s_cx, s_cy); else passed++;
            end
            if (ecount == 133 || ecount == 286) begin
                total++; if ({s_cx, s_cy} !== 20'h0) $display("FAIL s_past_coord got %0d,%0d exp 0,0", s_cx, s_cy); else passed++;
            end
            prev_hs = hs;
            s_prev_vs = s_vs;
        end
        total++; if (falls != 3) $display("FAIL hs_fall_count got %0d exp 3", falls); else passed++;
        total++; if (s_vfalls != 15) $display("FAIL s_frame_count got %0d exp 15", s_vfalls); else passed++;
    endtask

    task automatic test_coord_colour();
        advance_to(142, 34);
        total++; if ({cx, cy} !== 20'h0) $display("FAIL coord_v34 got %0d,%0d exp 0,0", cx, cy); else passed++;
        advance_to(142, 35);
        total++; if ({cx, cy} !== 20'h0) $display("FAIL coord_h142 got %0d,%0d exp 0,0", cx, cy); else passed++;
        total++; if (bl !== 1'b0) $display("FAIL blank_h142 got %b exp 0", bl); else passed++;
        advance_to(143, 35);
        total++; if ({cx, cy} !== {10'd1, 10'd0}) $display("FAIL coord_h143 got %0d,%0d exp 1,0", cx, cy); else passed++;
        total++; if ({r, g, b} !== 30'h0) $display("FAIL rgb_h143 got %h exp 0", {r, g, b}); else passed++;
        advance_to(144, 35);
        total++; if (bl !== 1'b1) $display("FAIL blank_h144 got %b exp 1", bl); else passed++;
        total++; if ({r, g, b} !== {10'h3FF, 10'h2AA, 10'h155}) $display("FAIL rgb_h144 got %h exp %h", {r, g, b}, {10'h3FF, 10'h2AA, 10'h155}); else passed++;
        advance_to(781, 35);
        total++; if ({cx, cy} !== {10'd639, 10'd0}) $display("FAIL coord_h781 got %0d,%0d exp 639,0", cx, cy); else passed++;
        advance_to(782, 35);
        total++; if ({cx, cy} !== 20'h0) $display("FAIL coord_h782 got %0d,%0d exp 0,0", cx, cy); else passed++;
        advance_to(783, 35);
        total++; if (bl !== 1'b1) $display("FAIL blank_h783 got %b exp 1", bl); else passed++;
        advance_to(784, 35);
        total++; if (bl !== 1'b0) $display("FAIL blank_h784 got %b exp 0", bl); else passed++;
        total++; if ({r, g, b} !== 30'h0) $display("FAIL rgb_h784 got %h exp 0", {r, g, b}); else passed++;
        advance_to(200, 36);
        total++; if ({cx, cy} !== {10'd58, 10'd1}) $display("FAIL coord_v36 got %0d,%0d exp 58,1", cx, cy); else passed++;
        en = 4'b1101;
        advance_to(300, 36);
        total++; if ({r, g, b} !== {10'h3FF, 10'h000, 10'h155}) $display("FAIL rgb_en1101 got %h exp %h", {r, g, b}, {10'h3FF, 10'h000, 10'h155}); else passed++;
        en = 4'b0010;
        iGreen = 10'h0F0;
        tick();
        total++; if ({r, g, b} !== {10'h000, 10'h0F0, 10'h000}) $display("FAIL rgb_en0010 got %h exp %h", {r, g, b}, {10'h000, 10'h0F0, 10'h000}); else passed++;
        en = 4'b0111;
    endtask

    task automatic test_mid_reset();
        advance_to(400, 36);
        iRST_N = 1'b0;
        tick();
        total++; if ({hs, vs, bl} !== 3'b110) $display("FAIL mid_rst_sync got %b exp 110", {hs, vs, bl}); else passed++;
        total++; if ({cx, cy} !== 20'h0) $display("FAIL mid_rst_coord got %h exp 0", {cx, cy}); else passed++;
        total++; if ({r, g, b} !== 30'h0) $display("FAIL mid_rst_rgb got %h exp 0", {r, g, b}); else passed++;
        iRST_N = 1'b1;
        tick();
        total++; if ({hs, vs, bl} !== 3'b000) $display("FAIL mid_rel_sync got %b exp 000", {hs, vs, bl}); else passed++;
        total++; if ({s_hs, s_vs} !== 2'b00) $display("FAIL mid_rel_s_sync got %b exp 00", {s_hs, s_vs}); else passed++;
        advance_to(96, 0);
        total++; if (hs !== 1'b1) $display("FAIL mid_hs_edge97 got %b exp 1", hs); else passed++;
    endtask

    initial begin
        test_reset();
        test_line_frame();
        test_coord_colour();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
